// File: rtl/dvp_frame_tx.sv
// DVP transmitter: streams RGB565 frame-buffer pixels as vsync/href/8-bit bytes, high byte first.
// Optional colour-bar source is compiled in with DVP_TX_TEST_PATTERN_EN.
`timescale 1ns/1ps

module dvp_frame_tx #(
  parameter int H_ACTIVE  = 320,
  parameter int V_ACTIVE  = 240,
  parameter int VSYNC_LEN = 1536,
  parameter int V_BACK    = 4000,
  parameter int H_BLANK   = 320,
  parameter int V_FRONT   = 1000,
  parameter int AW        = 17
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          en,
  input  logic          pattern_sel,
  input  logic [15:0]   din,
  output logic          rd_en,
  output logic [AW-1:0] addr,
  output logic          vsync,
  output logic          href,
  output logic [7:0]    d,
  output logic          frame_done,
  output logic          busy
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int LINE_LEN = 2 * H_ACTIVE;
  localparam int CNT_MAX  = max2(max2(max2(VSYNC_LEN, V_BACK), max2(LINE_LEN, H_BLANK)), V_FRONT);
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam int LW       = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  localparam logic [CW-1:0] C_VSYNC_END  = CW'(VSYNC_LEN - 1);
  localparam logic [CW-1:0] C_VBACK_END  = CW'(V_BACK - 1);
  localparam logic [CW-1:0] C_LINE_END   = CW'(LINE_LEN - 1);
  localparam logic [CW-1:0] C_HBLANK_END = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] C_VFRONT_END = CW'(V_FRONT - 1);
  localparam logic [CW-1:0] C_VBACK_RD   = CW'(V_BACK - 2);
  localparam logic [CW-1:0] C_HBLANK_RD  = CW'(H_BLANK - 2);
  localparam logic [CW-1:0] C_LINE_RD_LIM = CW'(LINE_LEN - 2);
  localparam logic [LW-1:0] L_LAST       = LW'(V_ACTIVE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_LINE,
    S_HBLANK,
    S_VFRONT
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [LW-1:0]   r_line;
  logic [LW-1:0]   w_line_nxt;

  logic            r_slot;
  logic            r_fetch;
  logic [7:0]      r_pix_lo;
  logic            r_rd_en;
  logic [AW-1:0]   r_addr;
  logic            r_vsync;
  logic            r_href;
  logic [7:0]      r_d;
  logic            r_frame_done;
  logic            r_busy;

  logic            w_slot_nxt;
  logic            w_href_nxt;
  logic [7:0]      w_d_nxt;
  logic [15:0]     w_word;
  logic            w_rd_gate;

  // NOTE: every variable gets a default first, so no path through this block can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_line_nxt  = r_line;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (en) w_state_nxt = S_VSYNC;
      end
      S_VSYNC: begin
        if (r_cnt == C_VSYNC_END) begin
          w_state_nxt = S_VBACK;
          w_cnt_nxt   = '0;
        end
      end
      S_VBACK: begin
        if (r_cnt == C_VBACK_END) begin
          w_state_nxt = S_LINE;
          w_cnt_nxt   = '0;
        end
      end
      S_LINE: begin
        if (r_cnt == C_LINE_END) begin
          w_cnt_nxt = '0;
          if (r_line == L_LAST) begin
            w_state_nxt = S_VFRONT;
            w_line_nxt  = '0;
          end else begin
            w_state_nxt = S_HBLANK;
            w_line_nxt  = r_line + 1'b1;
          end
        end
      end
      S_HBLANK: begin
        if (r_cnt == C_HBLANK_END) begin
          w_state_nxt = S_LINE;
          w_cnt_nxt   = '0;
        end
      end
      S_VFRONT: begin
        if (r_cnt == C_VFRONT_END) begin
          w_state_nxt = en ? S_VSYNC : S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_line_nxt  = '0;
      end
    endcase
  end

  // Outputs are registered from the next-cycle state, so each output lines up with its own state cycle.
  // A read slot sits two cycles ahead of the high byte it feeds: pre-line gap, then every even line cycle.
  always_comb begin
    w_slot_nxt = ((w_state_nxt == S_VBACK)  && (w_cnt_nxt == C_VBACK_RD)) ||
                 ((w_state_nxt == S_HBLANK) && (w_cnt_nxt == C_HBLANK_RD)) ||
                 ((w_state_nxt == S_LINE)   && !w_cnt_nxt[0] && (w_cnt_nxt < C_LINE_RD_LIM));
    w_href_nxt = (w_state_nxt == S_LINE);
    w_d_nxt    = 8'h00;
    if (w_href_nxt) w_d_nxt = w_cnt_nxt[0] ? r_pix_lo : w_word[15:8];
  end

`ifdef DVP_TX_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam int PCW   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int BPW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [PCW-1:0] P_COL_END = PCW'(H_ACTIVE - 1);
  localparam logic [BPW-1:0] P_BAR_END = BPW'(BAR_W - 1);

  logic            r_pat;
  logic [PCW-1:0]  r_col;
  logic [BPW-1:0]  r_bar_pos;
  logic [2:0]      r_bar;
  logic [2:0]      r_fetch_bar;
  logic            w_frame_start;

  function automatic logic [15:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    return 16'hFFFF;
      3'd1:    return 16'hFFE0;
      3'd2:    return 16'h07FF;
      3'd3:    return 16'h07E0;
      3'd4:    return 16'hF81F;
      3'd5:    return 16'hF800;
      3'd6:    return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  assign w_frame_start = (w_state_nxt == S_VSYNC) && (r_state != S_VSYNC);

  // Bar position follows the read slots, so the pattern shares the memory path's timing exactly.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_pat       <= 1'b0;
      r_col       <= '0;
      r_bar_pos   <= '0;
      r_bar       <= 3'd0;
      r_fetch_bar <= 3'd0;
    end else if (w_frame_start) begin
      r_pat     <= pattern_sel;
      r_col     <= '0;
      r_bar_pos <= '0;
      r_bar     <= 3'd0;
    end else if (r_slot) begin
      r_fetch_bar <= r_bar;
      if (r_col == P_COL_END) begin
        r_col     <= '0;
        r_bar_pos <= '0;
        r_bar     <= 3'd0;
      end else begin
        r_col <= r_col + 1'b1;
        if (r_bar_pos == P_BAR_END) begin
          r_bar_pos <= '0;
          if (r_bar != 3'd7) r_bar <= r_bar + 1'b1;
        end else begin
          r_bar_pos <= r_bar_pos + 1'b1;
        end
      end
    end
  end

  assign w_word    = r_pat ? bar_rgb(r_fetch_bar) : din;
  assign w_rd_gate = ~r_pat;
`else
  logic w_unused_pattern_sel;
  assign w_unused_pattern_sel = pattern_sel;
  assign w_word    = din;
  assign w_rd_gate = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments only; blocking stays in the comb blocks.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_line       <= '0;
      r_slot       <= 1'b0;
      r_fetch      <= 1'b0;
      r_pix_lo     <= 8'h00;
      r_rd_en      <= 1'b0;
      r_addr       <= '0;
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_d          <= 8'h00;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_line       <= w_line_nxt;
      r_slot       <= w_slot_nxt;
      r_fetch      <= r_slot;
      if (r_fetch) r_pix_lo <= w_word[7:0];
      r_rd_en      <= w_slot_nxt & w_rd_gate;
      if ((w_state_nxt == S_VSYNC) || (w_state_nxt == S_IDLE)) r_addr <= '0;
      else if (r_slot)                                         r_addr <= r_addr + 1'b1;
      r_vsync      <= (w_state_nxt == S_VSYNC);
      r_href       <= w_href_nxt;
      r_d          <= w_d_nxt;
      r_frame_done <= (w_state_nxt == S_VFRONT) && (w_cnt_nxt == C_VFRONT_END);
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  assign rd_en      = r_rd_en;
  assign addr       = r_addr;
  assign vsync      = r_vsync;
  assign href       = r_href;
  assign d          = r_d;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_dvp_frame_tx.sv
// Self-checking bench for dvp_frame_tx: fixed vectors, corner sequences and a randomized frame-level model.
`timescale 1ns/1ps

module tb_dvp_frame_tx;

  localparam int H   = 4;
  localparam int V   = 2;
  localparam int VS  = 3;
  localparam int VB  = 4;
  localparam int HB  = 3;
  localparam int VF  = 2;
  localparam int AW  = 17;
  localparam int LINE_PERIOD = 2 * H + HB;
  localparam int FRAME_LEN   = VS + VB + V * 2 * H + (V - 1) * HB + VF;

  logic          pclk = 1'b0;
  logic          rst  = 1'b1;
  logic          en   = 1'b0;
  logic          pattern_sel = 1'b0;
  logic [15:0]   din  = 16'h0000;
  logic          rd_en;
  logic [AW-1:0] addr;
  logic          vsync;
  logic          href;
  logic [7:0]    d;
  logic          frame_done;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 pclk = ~pclk;

  dvp_frame_tx #(
    .H_ACTIVE(H), .V_ACTIVE(V), .VSYNC_LEN(VS), .V_BACK(VB),
    .H_BLANK(HB), .V_FRONT(VF), .AW(AW)
  ) u_dut (
    .pclk(pclk), .rst(rst), .en(en), .pattern_sel(pattern_sel), .din(din),
    .rd_en(rd_en), .addr(addr), .vsync(vsync), .href(href), .d(d),
    .frame_done(frame_done), .busy(busy)
  );

`ifdef DVP_TX_TEST_PATTERN_EN
  logic          pat_sel2 = 1'b1;
  logic [15:0]   din2 = 16'hA5A5;
  logic          rd_en2;
  logic [AW-1:0] addr2;
  logic          vsync2;
  logic          href2;
  logic [7:0]    d2;
  logic          frame_done2;
  logic          busy2;

  dvp_frame_tx #(
    .H_ACTIVE(8), .V_ACTIVE(V), .VSYNC_LEN(VS), .V_BACK(VB),
    .H_BLANK(HB), .V_FRONT(VF), .AW(AW)
  ) u_pat (
    .pclk(pclk), .rst(rst), .en(en), .pattern_sel(pat_sel2), .din(din2),
    .rd_en(rd_en2), .addr(addr2), .vsync(vsync2), .href(href2), .d(d2),
    .frame_done(frame_done2), .busy(busy2)
  );
`endif

  // Frame buffer: returns addr+0x1000 in the cycle after a read, noise otherwise.
  initial begin : frame_buffer
    logic          rr;
    logic [AW-1:0] aa;
    forever begin
      @(negedge pclk);
      rr = rd_en;
      aa = addr;
      @(posedge pclk);
      #1;
      din = rr ? (16'h1000 + aa[15:0]) : 16'($urandom);
    end
  end

  typedef struct packed {
    logic          vsync;
    logic          href;
    logic [7:0]    d;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic          frame_done;
    logic          busy;
  } exp_t;

  typedef struct {
    int       cyc;
    bit       en;
    bit       vs;
    bit       hr;
    bit [7:0] d;
    bit       rd;
    int       addr;
    bit       fd;
    bit       busy;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".vsync"},      32'(vsync),      32'(e.vsync));
    check({tag, ".href"},       32'(href),       32'(e.href));
    check({tag, ".d"},          32'(d),          32'(e.d));
    check({tag, ".rd_en"},      32'(rd_en),      32'(e.rd_en));
    check({tag, ".addr"},       32'(addr),       32'(e.addr));
    check({tag, ".frame_done"}, 32'(frame_done), 32'(e.frame_done));
    check({tag, ".busy"},       32'(busy),       32'(e.busy));
  endtask

  // Expected outputs at position pos of a frame (pos < 0 means idle), derived from the frame timeline.
  function automatic exp_t model_at(input int pos);
    exp_t        e;
    int          ls;
    int          o;
    int          rc;
    int          nreads;
    logic [15:0] w;
    e = '0;
    if (pos < 0) return e;
    nreads       = 0;
    e.busy       = 1'b1;
    e.vsync      = (pos < VS);
    e.frame_done = (pos == FRAME_LEN - 1);
    for (int l = 0; l < V; l++) begin
      ls = VS + VB + l * LINE_PERIOD;
      o  = pos - ls;
      if (o >= 0 && o < 2 * H) begin
        e.href = 1'b1;
        w      = 16'(32'h1000 + l * H + o / 2);
        e.d    = (o % 2 == 0) ? w[15:8] : w[7:0];
      end
      for (int p = 0; p < H; p++) begin
        rc = ls + 2 * p - 2;
        if (rc == pos) e.rd_en = 1'b1;
        if (rc < pos)  nreads++;
      end
    end
    e.addr = AW'(nreads);
    return e;
  endfunction

  function automatic int next_pos(input int p, input bit r, input bit e);
    if (r)                  return -1;
    if (p < 0)              return e ? 0 : -1;
    if (p == FRAME_LEN - 1) return e ? 0 : -1;
    return p + 1;
  endfunction

  // Reset for one edge with en=1; the k-th following negedge samples frame cycle k.
  task automatic start_frame();
    @(negedge pclk);
    rst = 1'b1;
    en  = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
  endtask

  vec_t tbl [18];

  initial begin
    exp_t e;
    int   cyc;
    int   pos;
    int   q[$];

    tbl[0]  = '{1,  1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1};
    tbl[1]  = '{3,  1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1};
    tbl[2]  = '{4,  1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1};
    tbl[3]  = '{6,  1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1};
    tbl[4]  = '{7,  1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b1};
    tbl[5]  = '{8,  1'b1, 1'b0, 1'b1, 8'h10, 1'b1, 1, 1'b0, 1'b1};
    tbl[6]  = '{9,  1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 2, 1'b0, 1'b1};
    tbl[7]  = '{10, 1'b1, 1'b0, 1'b1, 8'h10, 1'b1, 2, 1'b0, 1'b1};
    tbl[8]  = '{11, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 3, 1'b0, 1'b1};
    tbl[9]  = '{15, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 4, 1'b0, 1'b1};
    tbl[10] = '{16, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4, 1'b0, 1'b1};
    tbl[11] = '{17, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 4, 1'b0, 1'b1};
    tbl[12] = '{19, 1'b1, 1'b0, 1'b1, 8'h10, 1'b1, 5, 1'b0, 1'b1};
    tbl[13] = '{20, 1'b1, 1'b0, 1'b1, 8'h04, 1'b0, 6, 1'b0, 1'b1};
    tbl[14] = '{26, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 8, 1'b0, 1'b1};
    tbl[15] = '{27, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8, 1'b0, 1'b1};
    tbl[16] = '{28, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8, 1'b1, 1'b1};
    tbl[17] = '{29, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1};

    // Reset state, with en already high
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(negedge pclk);
    check_all("reset", '0);

    // First frame against fixed vectors; pattern_sel must be ignored in the default build
`ifndef DVP_TX_TEST_PATTERN_EN
    pattern_sel = 1'b1;
`endif
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 18; i++) begin
      while (cyc < tbl[i].cyc) begin
        @(negedge pclk);
        cyc++;
      end
      e            = '0;
      e.vsync      = tbl[i].vs;
      e.href       = tbl[i].hr;
      e.d          = tbl[i].d;
      e.rd_en      = tbl[i].rd;
      e.addr       = AW'(tbl[i].addr);
      e.frame_done = tbl[i].fd;
      e.busy       = tbl[i].busy;
      check_all($sformatf("vec_c%0d", tbl[i].cyc), e);
      en = tbl[i].en;
    end
    pattern_sel = 1'b0;

    // en dropped during line 0: frame completes, then idle
    start_frame();
    for (int c = 1; c <= 40; c++) begin
      @(negedge pclk);
      if (c == 10) en = 1'b0;
      if (c == 26) check("drop.last_byte", 32'(d), 32'h07);
      if (c == 28) check("drop.frame_done", 32'(frame_done), 32'd1);
      if (c == 29) begin
        check("drop.busy_after", 32'(busy), 32'd0);
        check("drop.vsync_after", 32'(vsync), 32'd0);
      end
      if (c == 40) begin
        check("drop.busy_idle", 32'(busy), 32'd0);
        check("drop.vsync_idle", 32'(vsync), 32'd0);
      end
    end

    // Reset during line 1, then a fresh frame
    start_frame();
    repeat (21) @(negedge pclk);
    rst = 1'b1;
    @(negedge pclk);
    check_all("midrst", '0);
    rst = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge pclk);
      if (c == 1) begin
        check("restart.vsync", 32'(vsync), 32'd1);
        check("restart.addr", 32'(addr), 32'd0);
        check("restart.busy", 32'(busy), 32'd1);
      end
      if (c == 8) begin
        check("restart.href", 32'(href), 32'd1);
        check("restart.d", 32'(d), 32'h10);
      end
    end

    // Back-to-back frames: read addresses 0..7 twice
    start_frame();
    q.delete();
    for (int c = 1; c <= 2 * FRAME_LEN; c++) begin
      @(negedge pclk);
      if (rd_en) q.push_back(int'(addr));
    end
    check("b2b.read_count", 32'(q.size()), 32'd16);
    for (int i = 0; i < q.size() && i < 16; i++)
      check($sformatf("b2b.addr%0d", i), 32'(q[i]), 32'(i % 8));

`ifdef DVP_TX_TEST_PATTERN_EN
    begin : pattern_test
      logic [7:0] bars [16];
      logic [7:0] got [$];
      int         nrd;
      bars = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
               8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
      nrd = 0;
      start_frame();
      for (int c = 1; c <= 44; c++) begin
        @(negedge pclk);
        if (href2) got.push_back(d2);
        if (rd_en2) nrd++;
        if (c == 1) begin
          check("pat.vsync", 32'(vsync2), 32'd1);
          check("pat.busy", 32'(busy2), 32'd1);
        end
        if (c == 44) begin
          check("pat.frame_done", 32'(frame_done2), 32'd1);
          check("pat.addr_end", 32'(addr2), 32'd16);
        end
      end
      check("pat.byte_count", 32'(got.size()), 32'd32);
      for (int i = 0; i < got.size() && i < 32; i++)
        check($sformatf("pat.byte%0d", i), 32'(got[i]), 32'(bars[i % 16]));
      check("pat.rd_en_count", 32'(nrd), 32'd0);
    end
`endif

    // Randomized en/rst/pattern_sel against the frame-level model
    @(negedge pclk);
    rst = 1'b1;
    en  = 1'b1;
    @(negedge pclk);
    pos = -1;
    for (int i = 0; i < 800; i++) begin
      check_all($sformatf("rnd%0d", i), model_at(pos));
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 29) == 0) en = ~en;
`ifndef DVP_TX_TEST_PATTERN_EN
      pattern_sel = 1'($urandom);
`endif
      pos = next_pos(pos, rst, en);
      @(negedge pclk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dvp_frame_tx.md
Name: dvp_frame_tx

Overview:
- DVP camera-bus transmitter: reads RGB565 pixels from a frame buffer and drives vsync/href/8-bit data with OV2640-style timing.
- Counterpart of the capture path: feeds the capture block in loopback builds and sensor-less bring-up.
- Emits one byte per clock, pixel high byte first.
- All outputs are registered and change on the rising edge of pclk.

Parameters:
- H_ACTIVE, 320, pixels per line (line = 2*H_ACTIVE byte cycles with href high)
- V_ACTIVE, 240, lines per frame
- VSYNC_LEN, 1536, cycles vsync is held high
- V_BACK, 4000, cycles from vsync fall to first href rise; must be >= 2
- H_BLANK, 320, cycles href is low between lines; must be >= 2
- V_FRONT, 1000, cycles after the last line before the frame ends
- AW, 17, address width; H_ACTIVE*V_ACTIVE <= 2^AW

Ports:
- pclk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- en  in  1  start/continue frames; sampled only at frame boundaries
- pattern_sel  in  1  select internal colour bars (see Optional Feature)
- din  in  16  RGB565 pixel from the frame buffer; valid the cycle after rd_en
- rd_en  out  1  frame-buffer read strobe
- addr  out  AW  pixel address for the read
- vsync  out  1  frame sync, active high
- href  out  1  line valid, active high
- d  out  8  data byte
- frame_done  out  1  one-cycle pulse at the end of each frame
- busy  out  1  high whenever the FSM is not IDLE

Behaviour:
- Reset (synchronous, takes effect on the next edge; also applies mid-frame): vsync=0, href=0, d=0, addr=0, rd_en=0, frame_done=0, busy=0, state=IDLE, all counters=0.
- State machine: IDLE -> VSYNC -> VBACK -> LINE -> (HBLANK -> LINE)* -> VFRONT -> VSYNC or IDLE.
- IDLE: all outputs at reset values. When en=1, go to VSYNC on the next cycle.
- VSYNC: vsync=1 for exactly VSYNC_LEN cycles. addr resets to 0.
- VBACK: V_BACK cycles, vsync=0, href=0.
- LINE: href=1 for exactly 2*H_ACTIVE cycles. For pixel p the byte order is d = din[15:8] on the even cycle, then din[7:0] on the odd cycle.
- HBLANK: H_BLANK cycles, href=0. Entered after every line except line V_ACTIVE-1.
- VFRONT: V_FRONT cycles, href=0. frame_done=1 on its last cycle. Next state is VSYNC if en=1 on that cycle, otherwise IDLE.
- d=0 whenever href=0.
- Read pipeline:
  - rd_en=1 with addr=A in cycle T.
  - din for A is valid in T+1 and is captured into the pixel register at the end of T+1.
  - The high byte of pixel A appears on d in T+2.
  - Hence rd_en for a line's first pixel occurs in the final 2nd-to-last cycle of VBACK/HBLANK, and during a line rd_en pulses every other cycle.
  - Exactly H_ACTIVE reads per line and H_ACTIVE*V_ACTIVE per frame.
- addr = line*H_ACTIVE + col. It increments by 1 after each rd_en, is held otherwise, never wraps within a frame, and returns to 0 at VSYNC.
- en falling mid-frame has no effect; the frame completes.
- busy=1 from the first VSYNC cycle through the last VFRONT cycle.

Optional Feature:
- Macro: DVP_TX_TEST_PATTERN_EN.
- Defined, with pattern_sel=1 (sampled at VSYNC and held for the whole frame):
  - The pixel word is internal colour bars instead of din; rd_en stays 0.
  - addr still counts as normal (it advances on the internal read slot).
  - 8 vertical bars of width H_ACTIVE/8 pixels, in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Timing is identical to memory mode.
- Not defined: pattern_sel is ignored, no pattern logic is synthesised, and data always comes from din.

Test Plan:
Bench parameters: H_ACTIVE=4, V_ACTIVE=2, VSYNC_LEN=3, V_BACK=4, H_BLANK=3, V_FRONT=2; din = {addr+16'h1000} one cycle after rd_en.
- en=1 from reset release -> VSYNC starts on the 1st cycle after rst falls. vsync high for 3 cycles, href first rises 7 cycles after vsync rises, frame_done pulses on cycle 28, and the next vsync starts on cycle 29.
- Line 0 data -> d = 10,00,10,01,10,02,10,03 (hex) with href high for exactly 8 cycles. rd_en at addr 0..3 occurs 2 cycles before each high byte. Line 1 uses addrs 4..7 after 3 href-low cycles.
- en dropped during line 0 -> the frame completes fully, frame_done pulses, then IDLE with busy=0 and vsync held 0.
- rst asserted during line 1 -> the next cycle shows href=0, vsync=0, d=0, addr=0, rd_en=0. With en=1 after release, a fresh frame restarts from VSYNC.
- Back-to-back frames with en held 1 -> addr sequence 0..7 repeats and there are exactly 8 rd_en pulses per frame.
- With DVP_TX_TEST_PATTERN_EN defined, H_ACTIVE=8, pattern_sel=1 -> line bytes are FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00 and rd_en never asserts.
